increment_term_generator: RTL
=============================

# increment_term_generator

Streams the per-element comparator terms K_n = A_0·(2n+1) − C_0 and K_n = A_0·(2n+1) + C_0 for a runtime-selected number of array elements. It accepts a precomputed cosine term C_0, typically from the shared CORDIC stage. It is the parametrised successor of the fixed 33-element incrementer. The block adds a configurable element count, a parameterised A_0, a valid/ready output stream with backpressure, abort, and saturating arithmetic. It sits between the CORDIC cosine stage and the per-element delay comparators.

## Interface
- DW_INTEGER, 18, integer bits of output terms (sign bit is extra)
- DW_FRACTION, 6, fractional bits for all fixed-point values
- DW_C0, 23, width of signed C_0 input (same fraction as outputs)
- MAX_ELEMENTS, 64, maximum elements per run (≥2)
- A0, 1054, unsigned A_0 in raw fixed-point (1054 = 16.46875 at DW_FRACTION=6)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate the current run
- c0  in  DW_C0  signed C_0, captured on accepted start
- n_elements  in  $clog2(MAX_ELEMENTS)+1  element count, captured on accepted start
- busy  out  1  high in every state except IDLE
- out_valid  out  1  term pair valid
- out_ready  in  1  downstream accepts the pair
- term_pos  out  DW_INTEGER+DW_FRACTION+1  signed A_0(2n+1) − C_0
- term_neg  out  DW_INTEGER+DW_FRACTION+1  signed A_0(2n+1) + C_0
- element_idx  out  $clog2(MAX_ELEMENTS)  current n
- last  out  1  high with the final pair of the run
- done  out  1  one-cycle pulse after the final handshake or on an empty run
- sat  out  1  sticky flag: a saturation occurred this run

## Operation
- States: IDLE, LOAD, STREAM.
- IDLE: when start=1, capture c0 and the effective count N, clear sat, and go to LOAD.
  - N = min(n_elements, MAX_ELEMENTS).
  - If N=0, no data is produced: done pulses the next cycle and the state stays IDLE.
- LOAD: compute term_pos = A0 − c0 and term_neg = A0 + c0, saturated. Set idx=0 and go to STREAM.
- STREAM: out_valid=1.
  - On handshake (out_valid & out_ready) with idx<N−1: add 2·A0 to both terms (saturating) and increment idx.
  - On handshake with idx=N−1: go to IDLE and pulse done.
- last = out_valid & (idx==N−1).
- Arithmetic is signed with one guard bit beyond the output width. Results clamp to ±(2^(DW_INTEGER+DW_FRACTION) − 1). Any clamp sets sat until the next accepted start.
- abort (any non-IDLE state) takes the block to IDLE at the next edge. No done pulse and no last are issued. Abort has priority over a same-cycle handshake.
- start while busy is ignored. start and abort together in IDLE: start wins.

## Timing
- Reset values: busy, out_valid, last, done, sat = 0; term_pos, term_neg, element_idx = 0; state = IDLE.
- Outputs term_pos, term_neg, element_idx and last are forced to 0 whenever out_valid=0.
- Latency: start accepted at edge t → out_valid high from cycle t+2.
- Throughput: 1 pair per cycle under continuous out_ready. There is no bubble between elements.
- Backpressure: while out_valid=1 and out_ready=0, all outputs are held stable.
- done is high for exactly one cycle, the one after the final handshake. busy falls in the same cycle.
- rst mid-run: all outputs return to reset values at the next edge. A partial run is never resumed.

## Structure
- Package increment_term_pkg holds:
  - the state enum
  - default A0 constant
  - the saturating add function sat_add(a, b) parameterised by output width
- Sub-module sat_accumulator holds one saturating term register with load/increment/hold controls. It is instantiated twice, for pos and neg.
- The FSM, idx counter and handshake logic live in the top module.

## Test plan
- Default params, c0=0, n_elements=4, out_ready=1 → both streams output raw 1054, 3162, 5270, 7378. last is high on idx 3. done pulses one cycle later. sat=0.
- c0=+64 (1.0), n_elements=2 → term_pos 990, 3098; term_neg 1118, 3226.
- n_elements=3 with out_ready toggling 1,0,0,1,… → each pair is held stable while stalled. Exactly 3 handshakes occur, idx order 0,1,2.
- DW_INTEGER=8, c0=0, n_elements=10 → idx 0..7 give 1054·(2n+1). idx 8 and 9 clamp to 16383 and sat=1.
- abort asserted at idx 2 of an 8-element run → out_valid is low at the next edge. No last and no done. A new start then runs normally from idx 0.
- n_elements=0 → done pulses 1 cycle after start, with out_valid never high. n_elements=100 → exactly 64 pairs. rst asserted mid-stream → all outputs zero next cycle.

Source files
------------

// File: rtl/increment_term_pkg.sv
// Shared types and helpers for the increment term generator.
package increment_term_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // A_0 = 16.46875 with six fractional bits
  localparam int unsigned A0_DEFAULT = 1054;

  typedef struct packed {
    logic [63:0] val;
    logic        clamped;
  } sat_res_t;

  // Exact signed add, clamped symmetrically to +/-(2^(out_w-1) - 1).
  // Operands are far narrower than 64 bits, so the wide sum carries the guard bit.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned out_w);
    logic signed [63:0] sum;
    logic signed [63:0] lim;
    sat_res_t r;
    sum       = a + b;
    lim       = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    r.val     = sum;
    r.clamped = 1'b0;
    if (sum > lim) begin
      r.val     = lim;
      r.clamped = 1'b1;
    end else if (sum < -lim) begin
      r.val     = -lim;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/increment_term_generator_sat_accumulator.sv
// One saturating term register: load A_0 + offset, or step by 2*A_0, else hold.
module sat_accumulator
  import increment_term_pkg::*;
#(
  parameter int          OUT_W = 25,
  parameter int          ADD_W = 24,
  parameter int unsigned A0    = A0_DEFAULT
) (
  input  logic                    clk,
  input  logic                    load,
  input  logic                    inc,
  input  logic signed [ADD_W-1:0] load_add,
  output logic signed [OUT_W-1:0] value,
  output logic                    clamp
);

  localparam logic signed [63:0] A0_S = $signed(64'(A0));
  localparam logic signed [63:0] STEP = A0_S <<< 1;

  sat_res_t res;
  logic     unused_hi;

  // Select the operation for this cycle and flag any clamp it causes
  always_comb begin
    res = '0;
    if (load) begin
      res = sat_add(A0_S, 64'(load_add), unsigned'(OUT_W));
    end else if (inc) begin
      res = sat_add(64'(value), STEP, unsigned'(OUT_W));
    end
    clamp = (load | inc) & res.clamped;
  end

  assign unused_hi = ^res.val[63:OUT_W];

  // Term register: data only, never reset (outputs are masked while idle)
  always_ff @(posedge clk) begin
    if (load | inc) begin
      value <= res.val[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/increment_term_generator.sv
// Streams A_0(2n+1) -/+ C_0 term pairs for n = 0..N-1 with valid/ready,
// abort and saturating arithmetic.
module increment_term_generator
  import increment_term_pkg::*;
#(
  parameter int          DW_INTEGER   = 18,
  parameter int          DW_FRACTION  = 6,
  parameter int          DW_C0        = 23,
  parameter int          MAX_ELEMENTS = 64,
  parameter int unsigned A0           = A0_DEFAULT
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic signed [DW_C0-1:0]                   c0,
  input  logic [$clog2(MAX_ELEMENTS):0]             n_elements,
  output logic                                      busy,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [DW_INTEGER+DW_FRACTION:0]    term_pos,
  output logic signed [DW_INTEGER+DW_FRACTION:0]    term_neg,
  output logic [$clog2(MAX_ELEMENTS)-1:0]           element_idx,
  output logic                                      last,
  output logic                                      done,
  output logic                                      sat
);

  localparam int OUT_W = DW_INTEGER + DW_FRACTION + 1;
  localparam int IW    = $clog2(MAX_ELEMENTS);
  localparam int NW    = IW + 1;
  localparam logic [NW-1:0] MAX_N = NW'(MAX_ELEMENTS);

  state_t                   state_p0, state_nx;
  logic [IW-1:0]            idx_p0;
  logic [NW-1:0]            n_p0;
  logic signed [DW_C0-1:0]  c0_p0;
  logic                     done_p0;
  logic                     sat_p0;

  logic [NW-1:0]            n_eff;
  logic                     accept;
  logic                     in_stream;
  logic                     hs;
  logic                     at_last;
  logic                     load_en;
  logic                     inc_en;
  logic signed [DW_C0:0]    c0_ext;
  logic signed [DW_C0:0]    c0_neg_ext;
  logic signed [OUT_W-1:0]  pos_p1, neg_p1;
  logic                     pos_clamp, neg_clamp;

  assign n_eff      = (n_elements > MAX_N) ? MAX_N : n_elements;
  assign accept     = (state_p0 == ST_IDLE) & start;
  assign in_stream  = (state_p0 == ST_STREAM);
  assign hs         = in_stream & out_ready & ~abort;
  assign at_last    = ({1'b0, idx_p0} == (n_p0 - NW'(1)));
  assign load_en    = (state_p0 == ST_LOAD) & ~abort;
  assign inc_en     = hs & ~at_last;
  assign c0_ext     = {c0_p0[DW_C0-1], c0_p0};
  assign c0_neg_ext = -c0_ext;

  // Next-state logic; abort wins over a same-cycle handshake
  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      ST_IDLE:   if (start && (n_eff != '0)) state_nx = ST_LOAD;
      ST_LOAD:   state_nx = abort ? ST_IDLE : ST_STREAM;
      ST_STREAM: begin
        if (abort)              state_nx = ST_IDLE;
        else if (hs && at_last) state_nx = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Control registers: state, element index, done pulse, sticky saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
      idx_p0   <= '0;
      done_p0  <= 1'b0;
      sat_p0   <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      done_p0  <= (accept && (n_eff == '0)) || (hs && at_last);
      if (load_en)     idx_p0 <= '0;
      else if (inc_en) idx_p0 <= idx_p0 + IW'(1);
      if (accept)                      sat_p0 <= 1'b0;
      else if (pos_clamp || neg_clamp) sat_p0 <= 1'b1;
    end
  end

  // Run parameters captured on an accepted start
  always_ff @(posedge clk) begin
    if (accept) begin
      c0_p0 <= c0;
      n_p0  <= n_eff;
    end
  end

  // ---- stage p1: saturating term accumulators ----
  sat_accumulator #(.OUT_W(OUT_W), .ADD_W(DW_C0 + 1), .A0(A0)) u_pos (
    .clk      (clk),
    .load     (load_en),
    .inc      (inc_en),
    .load_add (c0_neg_ext),
    .value    (pos_p1),
    .clamp    (pos_clamp)
  );

  sat_accumulator #(.OUT_W(OUT_W), .ADD_W(DW_C0 + 1), .A0(A0)) u_neg (
    .clk      (clk),
    .load     (load_en),
    .inc      (inc_en),
    .load_add (c0_ext),
    .value    (neg_p1),
    .clamp    (neg_clamp)
  );

  assign busy        = (state_p0 != ST_IDLE);
  assign out_valid   = in_stream;
  assign term_pos    = in_stream ? pos_p1 : '0;
  assign term_neg    = in_stream ? neg_p1 : '0;
  assign element_idx = in_stream ? idx_p0 : '0;
  assign last        = in_stream & at_last;
  assign done        = done_p0;
  assign sat         = sat_p0;

endmodule
